rx_bit_sampler: RTL and testbench
=================================

Name: rx_bit_sampler

Overview:
Oversampling front end of the UART receiver. It synchronises the serial line, counts oversampling edges and bit positions, and majority-votes three mid-bit samples. Each vote is presented as a sampled bit with a one-cycle valid strobe. The RX control FSM and the per-bit checkers (start, parity, stop) consume `sampled_bit`, `Smpl_Valid`, `bit_cnt` and `Bit_Done`.

Parameters:
- PRESCALE_WIDTH, 6, width of the `Prescale` input.
- BIT_CNT_WIDTH, 4, width of `bit_cnt`.

Ports:
- CLK, input, 1, oversampling clock (Prescale x baud).
- RST, input, 1, synchronous active-low reset.
- RX_IN, input, 1, asynchronous serial line; idle high.
- En, input, 1, sampling enable from the RX FSM; held high for the whole frame.
- Prescale, input, PRESCALE_WIDTH, oversampling ratio; legal values 8, 16, 32.
- sampled_bit, output, 1, registered majority-vote result of the current bit.
- Smpl_Valid, output, 1, one-cycle pulse when `sampled_bit` has just been updated.
- edge_cnt, output, PRESCALE_WIDTH, oversampling edge index within the current bit.
- bit_cnt, output, BIT_CNT_WIDTH, index of the current bit within the frame.
- Bit_Done, output, 1, high during the last edge of each bit period.

Behaviour:
- Reset: every flop is cleared only on a CLK rising edge with RST=0.
  - Reset values: `rx_sync1`, `rx_sync2` = 1; `sampled_bit` = 1; `Smpl_Valid` = 0; `edge_cnt` = 0; `bit_cnt` = 0; sample regs = 0; `P_lat` = 8.
  - A reset mid-frame abandons the frame; there is no residual pulse on the cycle after reset is released.
- Synchroniser: RX_IN passes through two flops. `rx_sync2` is the only line value used internally, so the line-to-sample latency is 2 cycles.
- Prescale latch:
  - `P_lat` is loaded on the first cycle En is sampled high (En rising, detected with a registered `En_d`).
  - `P_lat` holds while En stays high; Prescale changes mid-frame are ignored.
  - Any value other than 8, 16 or 32 latches as 8.
- Midpoint: m = P_lat/2, so m = 4, 8 or 16.
- Edge counter:
  - While En=1, `edge_cnt` increments every cycle from 0 to P_lat-1.
  - At P_lat-1 it wraps to 0 and `bit_cnt` increments.
  - `edge_cnt` counts from 0 on the first En-high cycle.
- Bit counter: saturates at 2^BIT_CNT_WIDTH - 1 and does not wrap. Frame length is enforced by the FSM.
- Bit_Done: combinational, = En AND (`edge_cnt` == P_lat-1).
- Sampling:
  - At the edge where `edge_cnt` == m-1, capture `rx_sync2` into s0.
  - At the edge where `edge_cnt` == m, capture `rx_sync2` into s1.
  - At the edge where `edge_cnt` == m+1: `sampled_bit` <= maj(s0, s1, `rx_sync2`) and `Smpl_Valid` <= 1.
  - `Smpl_Valid` is therefore high for exactly one cycle, the cycle in which `edge_cnt` == m+2.
  - maj = (a&b)|(a&c)|(b&c). Any single glitched sample is rejected.
- En low:
  - Synchronously clear `edge_cnt`, `bit_cnt`, s0, s1 and `Smpl_Valid` (`Smpl_Valid` is 0 the cycle after En falls).
  - `sampled_bit` holds its last value.
  - The synchroniser keeps running.
- En dropped mid-bit: no `Smpl_Valid` is produced for that partial bit, including when En falls on the `edge_cnt` == m+1 cycle.
- Simultaneous events: RST=0 overrides En. An En re-rise restarts from `edge_cnt` 0 and re-latches Prescale.

Test Plan:
1. Prescale=8, En high, RX_IN drives bits 0,1,0,1 (8 clocks each), aligned 2 cycles ahead -> `Smpl_Valid` pulses at `edge_cnt` 6 of each bit; `sampled_bit` 0,1,0,1; `Bit_Done` at `edge_cnt` 7; `bit_cnt` 0,1,2,3.
2. Prescale=16, bit=1 with `rx_sync2`=0 only at `edge_cnt` 8 -> `sampled_bit`=1. Repeat with two of samples 7/8/9 low -> `sampled_bit`=0. Repeat at Prescale=32 using samples 15/16/17.
3. Prescale=20 latched -> timing identical to Prescale=8. Change Prescale to 32 mid-frame -> no timing change until En re-rises.
4. Prescale=16, En falls at `edge_cnt`=9 of bit 2 -> no `Smpl_Valid`; next cycle `edge_cnt`=0, `bit_cnt`=0; `sampled_bit` holds bit 1's value.
5. RST=0 for one cycle at bit 5 with En held high -> next cycle all outputs are at reset values (`sampled_bit`=1); counting resumes from 0 at the first cycle after RST=1.
6. Run 20 bit periods at Prescale=8 -> `bit_cnt` saturates at 15 and never wraps; `Smpl_Valid` continues once per bit.

Source files
------------

// File: rtl/rx_bit_sampler.sv
// ---------------------------------------------------------------------------
// rx_bit_sampler : UART RX oversampling front end with 3-sample majority vote
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rx_bit_sampler #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      En,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      sampled_bit,
  output logic                      Smpl_Valid,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
  output logic                      Bit_Done
);

  localparam logic [PRESCALE_WIDTH-1:0] P_8   = PRESCALE_WIDTH'(8);
  localparam logic [PRESCALE_WIDTH-1:0] P_16  = PRESCALE_WIDTH'(16);
  localparam logic [PRESCALE_WIDTH-1:0] P_32  = PRESCALE_WIDTH'(32);
  localparam logic [PRESCALE_WIDTH-1:0] ONE   = PRESCALE_WIDTH'(1);
  localparam logic [BIT_CNT_WIDTH-1:0]  BIT_MAX = {BIT_CNT_WIDTH{1'b1}};

  logic                      rx_sync1;
  logic                      rx_sync2;
  logic                      en_d;
  logic                      s0;
  logic                      s1;
  logic [PRESCALE_WIDTH-1:0] p_lat;
  logic [PRESCALE_WIDTH-1:0] prescale_legal;
  logic [PRESCALE_WIDTH-1:0] p_last;
  logic [PRESCALE_WIDTH-1:0] mid;
  logic [PRESCALE_WIDTH-1:0] mid_m1;
  logic [PRESCALE_WIDTH-1:0] mid_p1;
  logic                      vote;

  always_comb begin
    prescale_legal = P_8;
    if (Prescale == P_8 || Prescale == P_16 || Prescale == P_32)
      prescale_legal = Prescale;
  end

  assign p_last   = p_lat - ONE;
  assign mid      = p_lat >> 1;
  assign mid_m1   = mid - ONE;
  assign mid_p1   = mid + ONE;
  assign vote     = (s0 & s1) | (s0 & rx_sync2) | (s1 & rx_sync2);
  assign Bit_Done = En && (edge_cnt == p_last);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rx_sync1    <= 1'b1;
      rx_sync2    <= 1'b1;
      en_d        <= 1'b0;
      p_lat       <= P_8;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      s0          <= 1'b0;
      s1          <= 1'b0;
      sampled_bit <= 1'b1;
      Smpl_Valid  <= 1'b0;
    end else begin
      rx_sync1   <= RX_IN;
      rx_sync2   <= rx_sync1;
      en_d       <= En;
      Smpl_Valid <= 1'b0;

      // edge_cnt is still 0 on the latch cycle, so the old p_lat cannot cause a wrap
      if (En && !en_d)
        p_lat <= prescale_legal;

      if (!En) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
        s0       <= 1'b0;
        s1       <= 1'b0;
      end else begin
        if (edge_cnt == p_last) begin
          edge_cnt <= '0;
          if (bit_cnt != BIT_MAX)
            bit_cnt <= bit_cnt + 1'b1;
        end else begin
          edge_cnt <= edge_cnt + ONE;
        end

        if (edge_cnt == mid_m1)
          s0 <= rx_sync2;
        if (edge_cnt == mid)
          s1 <= rx_sync2;
        if (edge_cnt == mid_p1) begin
          sampled_bit <= vote;
          Smpl_Valid  <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rx_bit_sampler.sv
// ---------------------------------------------------------------------------
// tb_rx_bit_sampler : scoreboard bench with frame-level reference model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rx_bit_sampler;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       En = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       sampled_bit;
  logic       Smpl_Valid;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       Bit_Done;

  rx_bit_sampler #(.PRESCALE_WIDTH(6), .BIT_CNT_WIDTH(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .En         (En),
    .Prescale   (Prescale),
    .sampled_bit(sampled_bit),
    .Smpl_Valid (Smpl_Valid),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .Bit_Done   (Bit_Done)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    bit v;
    int b;
  } exp_t;
  exp_t sbq[$];

  function automatic int legal_p(input int p);
    return (p == 8 || p == 16 || p == 32) ? p : 8;
  endfunction

  // Reference model: a frame is the run of En-high edges since En rose;
  // position within it gives edge and bit indices by division.
  int cyc = 0;
  bit sync1m = 1'b1;
  bit sync2m = 1'b1;
  bit inframe = 1'b0;
  int n = 0;
  int pm = 8;
  bit exp_sampled = 1'b1;
  bit frame_sv[$];

  always @(posedge CLK) begin
    bit old_s2;
    int e;
    int ones;
    exp_t x;
    cyc++;
    old_s2 = sync2m;
    if (!RST) begin
      sync1m = 1'b1; sync2m = 1'b1;
      inframe = 1'b0; n = 0; pm = 8; exp_sampled = 1'b1;
      frame_sv.delete();
    end else begin
      sync2m = sync1m;
      sync1m = RX_IN;
      if (!En) begin
        inframe = 1'b0; n = 0;
        frame_sv.delete();
      end else begin
        if (!inframe) begin
          inframe = 1'b1; n = 0; pm = legal_p(int'(Prescale));
          frame_sv.delete();
        end
        frame_sv.push_back(old_s2);
        e = n % pm;
        if (e == pm / 2 + 1) begin
          ones = int'(frame_sv[n-2]) + int'(frame_sv[n-1]) + int'(frame_sv[n]);
          x.cyc = cyc;
          x.v = (ones >= 2);
          x.b = (n / pm > 15) ? 15 : n / pm;
          exp_sampled = x.v;
          sbq.push_back(x);
        end
        n++;
      end
    end
  end

  // Per-cycle state check
  always @(negedge CLK) begin
    int ee;
    int eb;
    bit ed;
    if (cyc > 0) begin
      ee = inframe ? n % pm : 0;
      eb = inframe ? ((n / pm > 15) ? 15 : n / pm) : 0;
      ed = En && inframe && (n % pm == pm - 1);
      checks++;
      if (int'(edge_cnt) != ee || int'(bit_cnt) != eb || Bit_Done != ed || sampled_bit != exp_sampled) begin
        errors++;
        $display("FAIL state cyc=%0d got edge=%0d bit=%0d done=%0b smp=%0b expected edge=%0d bit=%0d done=%0b smp=%0b",
                 cyc, edge_cnt, bit_cnt, Bit_Done, sampled_bit, ee, eb, ed, exp_sampled);
      end
    end
  end

  // Scoreboard monitor
  always @(negedge CLK) begin
    exp_t x;
    if (cyc > 0) begin
      if (Smpl_Valid === 1'b1) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL spurious_valid cyc=%0d got valid=1 expected valid=0", cyc);
        end else begin
          x = sbq.pop_front();
          if (x.cyc != cyc || sampled_bit != x.v || int'(bit_cnt) != x.b) begin
            errors++;
            $display("FAIL sample cyc=%0d got bit=%0b bit_cnt=%0d expected cyc=%0d bit=%0b bit_cnt=%0d",
                     cyc, sampled_bit, bit_cnt, x.cyc, x.v, x.b);
          end
        end
      end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        x = sbq.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_valid cyc=%0d got valid=%0b expected valid=1 bit=%0b", cyc, Smpl_Valid, x.v);
      end
    end
  end

  task automatic run_frame(input int pres, input int nbits, input int gp,
                           input logic [31:0] mask, input int drop_at,
                           input int rst_at, input int chg_at,
                           input bit use_pat, input logic [31:0] pat);
    int p;
    int pos;
    int bi;
    bit bits[64];
    bit flip;
    p = legal_p(pres);
    for (int k = 0; k < 64; k++)
      bits[k] = use_pat ? pat[k % 32] : 1'($urandom_range(0, 1));
    Prescale = 6'(pres);
    for (int c = -2; c < nbits * p; c++) begin
      @(posedge CLK); #1;
      if (c == drop_at) begin
        En = 1'b0;
        break;
      end
      En  = (c >= 0);
      RST = (c == rst_at) ? 1'b0 : 1'b1;
      if (c == chg_at)
        Prescale = 6'd32;
      pos  = (c + 2) % p;
      bi   = (c + 2) / p;
      flip = ($urandom_range(0, 99) < gp);
      RX_IN = (bi < nbits) ? (bits[bi] ^ mask[pos] ^ flip) : 1'b1;
    end
    @(posedge CLK); #1;
    En = 1'b0; RST = 1'b1; RX_IN = 1'b1;
    repeat (4) @(posedge CLK);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int plist[6];
    plist = '{8, 16, 32, 20, 0, 63};
    RST = 1'b0; En = 1'b0; RX_IN = 1'b1; Prescale = 6'd8;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (3) @(posedge CLK);

    run_frame(8, 4, 0, 32'h0, -1, -1, -1, 1'b1, 32'hA);          // bits 0,1,0,1
    run_frame(16, 4, 0, 32'h0000_0100, -1, -1, -1, 1'b1, 32'hF); // one glitch rejected
    run_frame(16, 4, 0, 32'h0000_0180, -1, -1, -1, 1'b1, 32'hF); // two glitches win
    run_frame(32, 3, 0, 32'h0001_0000, -1, -1, -1, 1'b0, 32'h0);
    run_frame(32, 3, 0, 32'h0002_8000, -1, -1, -1, 1'b0, 32'h0);
    run_frame(20, 4, 0, 32'h0, -1, -1, -1, 1'b0, 32'h0);
    run_frame(8, 5, 0, 32'h0, -1, -1, 10, 1'b0, 32'h0);           // Prescale change mid-frame
    run_frame(16, 4, 0, 32'h0, 41, -1, -1, 1'b1, 32'h2);          // drop on edge 9 of bit 2
    run_frame(8, 8, 0, 32'h0, -1, 42, -1, 1'b0, 32'h0);           // reset during bit 5
    run_frame(8, 20, 0, 32'h0, -1, -1, -1, 1'b0, 32'h0);          // bit_cnt saturation

    for (int i = 0; i < 10; i++)
      run_frame(plist[$urandom_range(0, 5)], $urandom_range(1, 10), 15,
                32'h0, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 60) : -1,
                -1, -1, 1'b0, 32'h0);

    repeat (5) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d expected pending=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
